// File: rtl/alu_register_pkg.sv
// Shared types for the ALU/register leaf: default data width and the ALU opcode encoding.
// Optional flag outputs in this slice are enabled by ALU_REGISTER_UNIT_FLAGS_EN.
package alu_register_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_OR  = 3'b110,
    OP_AND = 3'b111
  } op_e;

endpackage

// File: rtl/alu_register_unit_alu_core.sv
// Combinational 8-op ALU with zero latency and no backpressure; results truncated to WIDTH.
// Zero/carry flags exist only when ALU_REGISTER_UNIT_FLAGS_EN is defined.
module alu_core
  import alu_register_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       oc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f
`ifdef ALU_REGISTER_UNIT_FLAGS_EN
  ,
  output logic             zf,
  output logic             cf
`endif
);

  always_comb begin
    f = '0;
    unique case (op_e'(oc))
      OP_ADD:  f = a + b;
      OP_SUB:  f = a - b;
      OP_MUL:  f = a * b;
      OP_DIV:  f = (b == '0) ? '0 : a / b;
      OP_NOT:  f = ~a;
      OP_XOR:  f = a ^ b;
      OP_OR:   f = a | b;
      OP_AND:  f = a & b;
      default: f = '0;
    endcase
  end

`ifdef ALU_REGISTER_UNIT_FLAGS_EN
  logic [WIDTH:0]     sum_w;
  logic [2*WIDTH-1:0] prod_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign prod_w = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign zf     = (f == '0);

  always_comb begin
    cf = 1'b0;
    unique case (op_e'(oc))
      OP_ADD:  cf = sum_w[WIDTH];
      OP_SUB:  cf = (a < b);
      OP_MUL:  cf = (prod_w[2*WIDTH-1:WIDTH] != '0);
      OP_DIV:  cf = (b == '0);
      default: cf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_register_unit.sv
// ALU/register leaf: combinational ALU (zero latency) plus a 1-cycle multifunction register, no backpressure.
// Build with ALU_REGISTER_UNIT_FLAGS_EN to expose zf/cf from the ALU.
module alu_register_unit
  import alu_register_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       oc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f,
  input  logic             cl,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             ir,
  input  logic             sl,
  input  logic             il,
  output logic [WIDTH-1:0] out
`ifdef ALU_REGISTER_UNIT_FLAGS_EN
  ,
  output logic             zf,
  output logic             cf
`endif
);

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .oc (oc),
    .a  (a),
    .b  (b),
    .f  (f)
`ifdef ALU_REGISTER_UNIT_FLAGS_EN
    ,
    .zf (zf),
    .cf (cf)
`endif
  );

  // Strict priority chain: exactly one action per edge, lower controls ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out <= '0;
    else if (cl)  out <= '0;
    else if (ld)  out <= in;
    else if (inc) out <= out + 1'b1;
    else if (dec) out <= out - 1'b1;
    else if (sr)  out <= {ir, out[WIDTH-1:1]};
    else if (sl)  out <= {out[WIDTH-2:0], il};
  end

endmodule

// File: tb/tb_alu_register_unit.sv
// Directed and randomized checks of the ALU opcodes and the register priority chain.
module tb_alu_register_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] oc;
  logic [3:0] a, b, f;
  logic       cl, ld, inc, dec, sr, ir, sl, il;
  logic [3:0] in, out;
`ifdef ALU_REGISTER_UNIT_FLAGS_EN
  logic       zf, cf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_register_unit dut (
    .clk(clk), .rst_n(rst_n), .oc(oc), .a(a), .b(b), .f(f),
    .cl(cl), .ld(ld), .in(in), .inc(inc), .dec(dec),
    .sr(sr), .ir(ir), .sl(sl), .il(il), .out(out)
`ifdef ALU_REGISTER_UNIT_FLAGS_EN
    , .zf(zf), .cf(cf)
`endif
  );

  function automatic logic [3:0] ref_alu(input int o, input int x, input int y);
    int r;
    case (o)
      0:       r = (x + y) % 16;
      1:       r = (x - y + 16) % 16;
      2:       r = (x * y) % 16;
      3:       r = (y == 0) ? 0 : x / y;
      4:       r = 15 - x;
      5:       r = x ^ y;
      6:       r = x | y;
      default: r = x & y;
    endcase
    return r[3:0];
  endfunction

  task automatic clr_ctl();
    cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0; ir = 0; il = 0; in = 4'd0;
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clr_ctl(); oc = 0; a = 0; b = 0;
    #2;
    n_cmp++;
    if (out !== 4'b0000) begin n_err++; $display("FAIL reset_init out=%b exp=0000", out); end
    @(negedge clk); rst_n = 1;
    ld = 1; in = 4'b1011;
    step();
    n_cmp++;
    if (out !== 4'b1011) begin n_err++; $display("FAIL reset_preload out=%b exp=1011", out); end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (out !== 4'b0000) begin n_err++; $display("FAIL reset_async out=%b exp=0000", out); end
    step();
    n_cmp++;
    if (out !== 4'b0000) begin n_err++; $display("FAIL reset_hold out=%b exp=0000", out); end
    @(negedge clk); rst_n = 1; ld = 1; in = 4'b0110;
    step();
    n_cmp++;
    if (out !== 4'b0110) begin n_err++; $display("FAIL reset_release_ld out=%b exp=0110", out); end
    clr_ctl();
  endtask

  task automatic test_alu_spot();
    logic [3:0] ta [6] = '{4'd9, 4'd3, 4'd7, 4'd13, 4'd6, 4'b0101};
    logic [3:0] tb [6] = '{4'd8, 4'd5, 4'd3, 4'd4,  4'd0, 4'd0};
    logic [2:0] to [6] = '{3'd0, 3'd1, 3'd2, 3'd3,  3'd3, 3'd4};
    logic [3:0] te [6] = '{4'b0001, 4'b1110, 4'b0101, 4'b0011, 4'b0000, 4'b1010};
    for (int i = 0; i < 6; i++) begin
      oc = to[i]; a = ta[i]; b = tb[i];
      #1;
      n_cmp++;
      if (f !== te[i]) begin
        n_err++;
        $display("FAIL alu_spot%0d oc=%b a=%b b=%b f=%b exp=%b", i, oc, a, b, f, te[i]);
      end
    end
  endtask

  task automatic test_alu_sweep();
    logic [3:0] e;
    for (int o = 0; o < 8; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          oc = 3'(o); a = 4'(x); b = 4'(y);
          #1;
          e = ref_alu(o, x, y);
          n_cmp++;
          if (f !== e) begin
            n_err++;
            $display("FAIL alu_sweep oc=%b a=%b b=%b f=%b exp=%b", oc, a, b, f, e);
          end
        end
  endtask

  task automatic test_wrap();
    @(negedge clk); clr_ctl(); ld = 1; in = 4'b1111;
    step();
    @(negedge clk); clr_ctl(); inc = 1;
    step();
    n_cmp++;
    if (out !== 4'b0000) begin n_err++; $display("FAIL wrap_inc out=%b exp=0000", out); end
    @(negedge clk); clr_ctl(); dec = 1;
    step();
    n_cmp++;
    if (out !== 4'b1111) begin n_err++; $display("FAIL wrap_dec out=%b exp=1111", out); end
    @(negedge clk); clr_ctl();
  endtask

  task automatic test_shifts();
    @(negedge clk); clr_ctl(); ld = 1; in = 4'b1001;
    step();
    @(negedge clk); clr_ctl(); sr = 1; ir = 1;
    step();
    n_cmp++;
    if (out !== 4'b1100) begin n_err++; $display("FAIL shift_right out=%b exp=1100", out); end
    @(negedge clk); clr_ctl(); sl = 1; il = 0;
    step();
    n_cmp++;
    if (out !== 4'b1000) begin n_err++; $display("FAIL shift_left out=%b exp=1000", out); end
    @(negedge clk); clr_ctl(); sl = 1; il = 1;
    step();
    n_cmp++;
    if (out !== 4'b0001) begin n_err++; $display("FAIL shift_left_il out=%b exp=0001", out); end
    @(negedge clk); clr_ctl();
  endtask

  task automatic test_priority();
    @(negedge clk); clr_ctl(); ld = 1; in = 4'b0101;
    step();
    @(negedge clk); clr_ctl(); cl = 1; ld = 1; inc = 1; in = 4'b1010;
    step();
    n_cmp++;
    if (out !== 4'b0000) begin n_err++; $display("FAIL prio_clear out=%b exp=0000", out); end
    @(negedge clk); clr_ctl(); ld = 1; inc = 1; sr = 1; in = 4'b0011;
    step();
    n_cmp++;
    if (out !== 4'b0011) begin n_err++; $display("FAIL prio_load out=%b exp=0011", out); end
    @(negedge clk); clr_ctl(); inc = 1; dec = 1;
    step();
    n_cmp++;
    if (out !== 4'b0100) begin n_err++; $display("FAIL prio_inc_dec out=%b exp=0100", out); end
    @(negedge clk); clr_ctl(); dec = 1; sr = 1; sl = 1;
    step();
    n_cmp++;
    if (out !== 4'b0011) begin n_err++; $display("FAIL prio_dec_shift out=%b exp=0011", out); end
    @(negedge clk); clr_ctl(); sr = 1; sl = 1; ir = 0; il = 1;
    step();
    n_cmp++;
    if (out !== 4'b0001) begin n_err++; $display("FAIL prio_sr_sl out=%b exp=0001", out); end
    @(negedge clk); clr_ctl();
    step();
    step();
    n_cmp++;
    if (out !== 4'b0001) begin n_err++; $display("FAIL prio_hold out=%b exp=0001", out); end
  endtask

  task automatic test_random();
    int m;
    @(negedge clk); clr_ctl(); ld = 1; in = 4'b0000;
    step();
    m = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cl  = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 5) == 0);
      inc = ($urandom_range(0, 2) == 0);
      dec = ($urandom_range(0, 2) == 0);
      sr  = ($urandom_range(0, 2) == 0);
      sl  = ($urandom_range(0, 2) == 0);
      ir  = 1'($urandom_range(0, 1));
      il  = 1'($urandom_range(0, 1));
      in  = 4'($urandom_range(0, 15));
      if (cl)       m = 0;
      else if (ld)  m = int'(in);
      else if (inc) m = (m + 1) % 16;
      else if (dec) m = (m + 15) % 16;
      else if (sr)  m = (m >> 1) + (ir ? 8 : 0);
      else if (sl)  m = ((m << 1) % 16) + (il ? 1 : 0);
      step();
      n_cmp++;
      if (out !== 4'(m)) begin
        n_err++;
        $display("FAIL random cyc=%0d out=%b exp=%b", i, out, 4'(m));
      end
    end
    @(negedge clk); clr_ctl();
  endtask

`ifdef ALU_REGISTER_UNIT_FLAGS_EN
  task automatic test_flags();
    oc = 3'd0; a = 4'd8; b = 4'd8;
    #1;
    n_cmp++;
    if (f !== 4'b0000 || zf !== 1'b1 || cf !== 1'b1) begin
      n_err++; $display("FAIL flags_add f=%b zf=%b cf=%b exp 0000/1/1", f, zf, cf);
    end
    oc = 3'd1; a = 4'd3; b = 4'd5;
    #1;
    n_cmp++;
    if (zf !== 1'b0 || cf !== 1'b1) begin
      n_err++; $display("FAIL flags_sub zf=%b cf=%b exp 0/1", zf, cf);
    end
    oc = 3'd2; a = 4'd7; b = 4'd3;
    #1;
    n_cmp++;
    if (cf !== 1'b1) begin n_err++; $display("FAIL flags_mul cf=%b exp=1", cf); end
    oc = 3'd3; a = 4'd6; b = 4'd0;
    #1;
    n_cmp++;
    if (zf !== 1'b1 || cf !== 1'b1) begin
      n_err++; $display("FAIL flags_div0 zf=%b cf=%b exp 1/1", zf, cf);
    end
    oc = 3'd4; a = 4'd15; b = 4'd0;
    #1;
    n_cmp++;
    if (zf !== 1'b1 || cf !== 1'b0) begin
      n_err++; $display("FAIL flags_not zf=%b cf=%b exp 1/0", zf, cf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_spot();
    test_alu_sweep();
`ifdef ALU_REGISTER_UNIT_FLAGS_EN
    test_flags();
`endif
    test_wrap();
    test_shifts();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_register_unit.md
Name: alu_register_unit

Overview:
- 4-bit datapath block with two independent sections.
- Section 1 is a combinational 8-operation ALU (oc, a, b -> f).
- Section 2 is a clocked 4-bit multifunction register supporting clear, load, increment, decrement, and shift right/left with serial inputs.
- Used as the arithmetic/storage leaf of the student processor datapath; the two sections share no signals except clk/rst_n, which only the register uses.

Parameters:
- WIDTH, 4, data width of a, b, f, in, out. All behaviour below is stated for WIDTH=4 and generalises bitwise.

Ports:
- clk  input  1  rising-edge clock (register only)
- rst_n  input  1  asynchronous active-low reset
- oc  input  3  ALU operation code
- a  input  WIDTH  ALU operand a (unsigned)
- b  input  WIDTH  ALU operand b (unsigned)
- f  output  WIDTH  ALU result
- cl  input  1  synchronous clear
- ld  input  1  synchronous load of in
- in  input  WIDTH  parallel load data
- inc  input  1  increment
- dec  input  1  decrement
- sr  input  1  shift right
- ir  input  1  serial bit shifted into MSB on sr
- sl  input  1  shift left
- il  input  1  serial bit shifted into LSB on sl
- out  output  WIDTH  register contents

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- ALU is purely combinational, zero latency; f is valid whenever oc/a/b are stable. It is unaffected by clk and rst_n. All results are truncated to WIDTH bits; operands are unsigned.
- ALU operation codes:
  - oc=000: f = a + b (mod 16)
  - oc=001: f = a - b (mod 16, two's-complement wrap)
  - oc=010: f = low 4 bits of a * b
  - oc=011: f = a / b (integer quotient); b=0 gives f = 0000
  - oc=100: f = ~a
  - oc=101: f = a ^ b
  - oc=110: f = a | b
  - oc=111: f = a & b
- Register reset: rst_n=0 forces out=0000 immediately, independent of clk. It holds 0000 while low. Deassertion takes effect from the next rising edge.
- Register update on a rising clk edge with rst_n=1. Fixed priority, highest first; exactly one action per edge:
  - 1. cl=1: out <= 0000.
  - 2. ld=1: out <= in.
  - 3. inc=1: out <= out+1; 1111 wraps to 0000.
  - 4. dec=1: out <= out-1; 0000 wraps to 1111.
  - 5. sr=1: out <= {ir, out[3:1]}.
  - 6. sl=1: out <= {out[2:0], il}.
  - 7. None active: out holds.
- Simultaneous controls: lower-priority controls are ignored. For example, inc=dec=1 increments; sr=sl=1 shifts right.
- Reset mid-operation: asynchronous reset overrides any pending action. The clock edge coinciding with rst_n=0 has no effect.

Optional Feature:
- Macro: ALU_REGISTER_UNIT_FLAGS_EN.
- When defined, two extra outputs are added.
- zf (1 bit): 1 when f==0000.
- cf (1 bit):
  - oc=000: carry out of bit 3.
  - oc=001: borrow (a<b).
  - oc=010: 1 when the full product exceeds 15.
  - oc=011: 1 when b=0 (divide-by-zero).
  - oc=100..111: 0.
- Both flags are combinational, same timing as f.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_register_pkg holds:
  - WIDTH default;
  - an enum of the 8 ALU opcodes (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_NOT, OP_XOR, OP_OR, OP_AND = 000..111).
- One natural sub-module: alu_core (combinational ALU, including optional flags). The register logic stays in the top-level.

Test Plan:
- Exhaustive ALU sweep of all 2048 {oc,a,b} combinations against a reference model. Spot checks:
  - 000: 9+8 -> 0001
  - 001: 3-5 -> 1110
  - 010: 7*3 -> 0101
  - 011: 13/4 -> 0011; 6/0 -> 0000
  - 100: ~0101 -> 1010
- Reset: rst_n=0 mid-cycle with out=1011 -> out=0000 immediately, before the next edge. Release rst_n, then ld=1, in=0110 -> out=0110 after one edge.
- Wrap-around:
  - out=1111, inc=1 -> 0000.
  - then dec=1 -> 1111.
- Shifts:
  - out=1001, sr=1, ir=1 -> 1100.
  - then sl=1, il=0 -> 1000.
- Priority:
  - out=0101, cl=ld=inc=1 -> 0000.
  - in=0011, ld=inc=sr=1 -> 0011.
  - inc=dec=1 from 0011 -> 0100.
  - all controls 0 -> holds 0100.
- Random stress: 1000 cycles of random cl/ld/in/inc/dec/sr/ir/sl/il, compared against a cycle-accurate priority model. With ALU_REGISTER_UNIT_FLAGS_EN defined: 8+8 -> f=0000, zf=1, cf=1.
